// File: rtl/line_clear_sequencer_if.sv
// Grid row RAM port between the line-clear sequencer and the RAM arbiter.
// Every access is a req/gnt handshake; read data arrives the cycle after the grant.
interface line_clear_sequencer_if #(
    parameter int COLS = 10,
    parameter int AW   = 5
);
    logic            ram_req;
    logic            ram_gnt;
    logic [AW-1:0]   ram_addr;
    logic            ram_we;
    logic [COLS-1:0] ram_wdata;
    logic [COLS-1:0] ram_rdata;

    modport master (
        output ram_req, ram_addr, ram_we, ram_wdata,
        input  ram_gnt, ram_rdata
    );

    modport slave (
        input  ram_req, ram_addr, ram_we, ram_wdata,
        output ram_gnt, ram_rdata
    );
endinterface

// File: rtl/line_clear_sequencer.sv
// Removes full grid rows after a lock, compacts survivors downward and zero-fills the top.
// Optional LINE_CLEAR_SCORE_EN adds a saturating 16-bit score accumulator output.
module line_clear_sequencer #(
    parameter int ROWS = 20,
    parameter int COLS = 10,
    parameter int AW   = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [AW-1:0] lines_cleared_o,
`ifdef LINE_CLEAR_SCORE_EN
    output logic [15:0]   score_o,
`endif
    line_clear_sequencer_if.master ram
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_EVAL, S_WRITE, S_CLEAR, S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);
    localparam logic [AW-1:0] ROWS_A   = AW'(ROWS);

    state_t          state_q, state_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [AW-1:0]   wr_q, wr_d;
    logic [COLS-1:0] buf_q, buf_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   lines_q, lines_d;
    logic            advance;

    always_comb begin
        state_d       = state_q;
        rd_d          = rd_q;
        wr_d          = wr_q;
        buf_d         = buf_q;
        cnt_d         = cnt_q;
        lines_d       = lines_q;
        advance       = 1'b0;
        busy_o        = 1'b0;
        done_o        = 1'b0;
        ram.ram_req   = 1'b0;
        ram.ram_we    = 1'b0;
        ram.ram_addr  = '0;
        ram.ram_wdata = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    rd_d    = '0;
                    wr_d    = '0;
                    cnt_d   = '0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                busy_o       = 1'b1;
                ram.ram_req  = 1'b1;
                ram.ram_addr = rd_q;
                if (ram.ram_gnt) state_d = S_EVAL;
            end
            S_EVAL: begin
                busy_o = 1'b1;
                buf_d  = ram.ram_rdata;
                // A full row is dropped by leaving wr behind; rows already in place skip the write.
                if (&ram.ram_rdata) begin
                    cnt_d   = cnt_q + 1'b1;
                    advance = 1'b1;
                end else if (wr_q == rd_q) begin
                    wr_d    = wr_q + 1'b1;
                    advance = 1'b1;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                busy_o        = 1'b1;
                ram.ram_req   = 1'b1;
                ram.ram_we    = 1'b1;
                ram.ram_addr  = wr_q;
                ram.ram_wdata = buf_q;
                if (ram.ram_gnt) begin
                    wr_d    = wr_q + 1'b1;
                    advance = 1'b1;
                end
            end
            S_CLEAR: begin
                busy_o       = 1'b1;
                ram.ram_req  = 1'b1;
                ram.ram_we   = 1'b1;
                ram.ram_addr = wr_q;
                if (ram.ram_gnt) begin
                    wr_d = wr_q + 1'b1;
                    if (wr_q == LAST_ROW) state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                lines_d = cnt_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Shared end-of-row step: the post-increment wr decides whether any top rows need zeroing.
        if (advance) begin
            if (rd_q == LAST_ROW) begin
                state_d = (wr_d == ROWS_A) ? S_DONE : S_CLEAR;
            end else begin
                rd_d    = rd_q + 1'b1;
                state_d = S_READ;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rd_q    <= '0;
            wr_q    <= '0;
            buf_q   <= '0;
            cnt_q   <= '0;
            lines_q <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            lines_q <= lines_d;
        end
    end

    assign lines_cleared_o = lines_q;

`ifdef LINE_CLEAR_SCORE_EN
    logic [15:0] score_q;
    logic [3:0]  score_inc;
    logic [16:0] score_sum;

    always_comb begin
        unique case (cnt_q)
            AW'(0):  score_inc = 4'd0;
            AW'(1):  score_inc = 4'd1;
            AW'(2):  score_inc = 4'd3;
            AW'(3):  score_inc = 4'd5;
            default: score_inc = 4'd8;
        endcase
        score_sum = {1'b0, score_q} + 17'(score_inc);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            score_q <= '0;
        end else if (state_q == S_DONE) begin
            score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end
    end

    assign score_o = score_q;
`endif

endmodule

// File: tb/tb_line_clear_sequencer.sv
// Directed and randomized clear passes against a row-list reference model and a RAM/arbiter model.
module tb_line_clear_sequencer;
    localparam int ROWS = 20;
    localparam int COLS = 10;
    localparam int AW   = 5;
    localparam logic [COLS-1:0] FULL = '1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          busy, done;
    logic [AW-1:0] lines;
`ifdef LINE_CLEAR_SCORE_EN
    logic [15:0]   score;
`endif

    line_clear_sequencer_if #(.COLS(COLS), .AW(AW)) ram ();

    line_clear_sequencer #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) dut (
        .clock           (clock),
        .reset           (reset),
        .start_i         (start),
        .busy_o          (busy),
        .done_o          (done),
        .lines_cleared_o (lines),
`ifdef LINE_CLEAR_SCORE_EN
        .score_o         (score),
`endif
        .ram             (ram)
    );

    always #5 clock = ~clock;

    int n_assert = 0, n_fail = 0;
    int done_cnt = 0, wr_cnt = 0, gmode = 0, gcyc = 0;
    int e_cnt, e_cyc, e_wr, exp_score = 0;
    logic [COLS-1:0] mem      [ROWS];
    logic [COLS-1:0] grid     [ROWS];
    logic [COLS-1:0] exp_mem  [ROWS];
    logic            load = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // RAM plus arbiter: accesses happen only on req&gnt, read data registered.
    always @(posedge clock) begin
        if (load) mem <= grid;
        else if (ram.ram_req === 1'b1 && ram.ram_gnt === 1'b1) begin
            if (ram.ram_we) mem[ram.ram_addr] <= ram.ram_wdata;
            else            ram.ram_rdata     <= mem[ram.ram_addr];
        end
    end

    // Grant driver and bus monitor: stall stability, we-implies-req, pulse counts.
    initial begin
        logic          p_stall;
        logic [16:0]   p_bus;
        logic [3:0]    pat;
        logic [1:0]    ph;
        pat = 4'b1001;
        p_stall = 1'b0;
        p_bus = '0;
        ram.ram_gnt = 1'b1;
        forever begin
            @(negedge clock);
            if (p_stall)
                chk("stall_hold", {ram.ram_req, ram.ram_we, ram.ram_addr, ram.ram_wdata}, p_bus);
            if (ram.ram_we === 1'b1) chk("we_implies_req", ram.ram_req, 1);
            if (done === 1'b1) done_cnt++;
            gcyc++;
            ph = gcyc[1:0];
            case (gmode)
                0:       ram.ram_gnt = 1'b1;
                1:       ram.ram_gnt = pat[ph];
                default: ram.ram_gnt = 1'($urandom_range(0, 1));
            endcase
            if (ram.ram_req === 1'b1 && ram.ram_we === 1'b1 && ram.ram_gnt) wr_cnt++;
            p_stall = (ram.ram_req === 1'b1) && !ram.ram_gnt;
            p_bus   = {ram.ram_req, ram.ram_we, ram.ram_addr, ram.ram_wdata};
        end
    end

    function automatic int score_inc(input int c);
        if (c == 0) return 0;
        if (c == 1) return 1;
        if (c == 2) return 3;
        if (c == 3) return 5;
        return 8;
    endfunction

    // Reference: survivors keep their order from the bottom, zeros fill the rest.
    task automatic model();
        int k, mv;
        bit found;
        k = 0; mv = 0; found = 0; e_cnt = 0; e_cyc = 0;
        for (int r = 0; r < ROWS; r++) exp_mem[r] = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (grid[r] == FULL) begin
                e_cnt++; found = 1; e_cyc += 2;
            end else begin
                exp_mem[k] = grid[r]; k++;
                if (found) begin mv++; e_cyc += 3; end
                else e_cyc += 2;
            end
        end
        e_cyc += e_cnt;
        e_wr = mv + e_cnt;
        exp_score = exp_score + score_inc(e_cnt);
        if (exp_score > 65535) exp_score = 65535;
    endtask

    task automatic load_grid();
        @(negedge clock); load = 1'b1;
        @(negedge clock); load = 1'b0;
    endtask

    task automatic run_pass(input int mode, input bit timed, input bit poke);
        int n, d0, w0, bad;
        gmode = mode;
        model();
        load_grid();
        d0 = done_cnt; w0 = wr_cnt;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        n = 1;
        while (done !== 1'b1 && n < 4000) begin
            start = (poke && n == 7);
            @(negedge clock);
            n++;
        end
        start = 1'b0;
        chk("done_seen", done, 1);
        if (timed) chk("done_cycle", n, e_cyc + 1);
        @(negedge clock);
        chk("busy_idle", busy, 0);
        chk("lines_cleared", lines, e_cnt);
        bad = 0;
        for (int r = 0; r < ROWS; r++) if (mem[r] !== exp_mem[r]) bad++;
        chk("ram_rows_wrong", bad, 0);
        chk("write_count", wr_cnt - w0, e_wr);
`ifdef LINE_CLEAR_SCORE_EN
        chk("score", score, exp_score);
`endif
        repeat (3) @(negedge clock);
        chk("done_pulses", done_cnt - d0, 1);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_req", ram.ram_req, 0);
        chk("rst_we", ram.ram_we, 0);
        chk("rst_addr", ram.ram_addr, 0);
        chk("rst_wdata", ram.ram_wdata, 0);
        chk("rst_lines", lines, 0);
`ifdef LINE_CLEAR_SCORE_EN
        chk("rst_score", score, 0);
`endif
        reset = 1'b1;

        // No full rows: pure scan, no writes.
        for (int r = 0; r < ROWS; r++) grid[r] = COLS'(r);
        run_pass(0, 1, 0);
        // Bottom row full: everything shifts down by one.
        for (int r = 0; r < ROWS; r++) grid[r] = (r == 0) ? FULL : COLS'(10'h155);
        run_pass(0, 1, 0);
        // Four scattered full rows, then the same grid under a stalling arbiter.
        for (int r = 0; r < ROWS; r++)
            grid[r] = (r == 0 || r == 1 || r == 2 || r == 5) ? FULL : COLS'(1);
        run_pass(0, 1, 0);
        run_pass(1, 0, 0);
        // Whole grid full.
        for (int r = 0; r < ROWS; r++) grid[r] = FULL;
        run_pass(0, 1, 0);
        // Random grids and grant patterns; start pokes while busy must be ignored.
        for (int t = 0; t < 8; t++) begin
            int m;
            for (int r = 0; r < ROWS; r++)
                grid[r] = ($urandom_range(0, 3) == 0) ? FULL : COLS'($urandom_range(0, 1022));
            m = (t < 2) ? 0 : int'($urandom_range(0, 2));
            run_pass(m, m == 0, t[0]);
        end

        // Reset while a WRITE is on the bus.
        gmode = 0;
        for (int r = 0; r < ROWS; r++) grid[r] = (r == 0) ? FULL : COLS'(10'h155);
        load_grid();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!(ram.ram_we === 1'b1 && ram.ram_wdata != '0) && n < 200) begin
            @(negedge clock); n++;
        end
        chk("write_reached", ram.ram_we, 1);
        reset = 1'b0;
        @(negedge clock);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_req", ram.ram_req, 0);
        chk("mid_rst_we", ram.ram_we, 0);
        chk("mid_rst_addr", ram.ram_addr, 0);
        chk("mid_rst_wdata", ram.ram_wdata, 0);
        chk("mid_rst_lines", lines, 0);
        exp_score = 0;
`ifdef LINE_CLEAR_SCORE_EN
        chk("mid_rst_score", score, 0);
`endif
        reset = 1'b1;
        run_pass(0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
